fb_vga_scanout: RTL and testbench
=================================

Name: fb_vga_scanout

Overview:
- Downstream consumer of the 1-bit-per-pixel frame RAM. The RAM holds a 240x240 image at addresses 0..57599, reads are registered on the falling edge, and rdata[0] carries the pixel.
- Generates 640x480@60 VGA timing and scans the RAM read port in raster order with integer upscaling.
- Maps each bit to an RGB colour and drives registered sync, data-enable and RGB outputs to the display pins.
- Read-only: it never asserts the RAM write enable.

Parameters:
- IMG_W, 240, image width in RAM pixels
- IMG_H, 240, image height in RAM pixels
- SCALE, 2, integer upscale factor; IMG_W*SCALE must not exceed H_ACT and IMG_H*SCALE must not exceed V_ACT
- X_OFF, 80, first active column of the image
- Y_OFF, 0, first active line of the image
- H_ACT/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing in pixels
- V_ACT/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing in lines
- FG_RGB, 24'hFFFFFF, colour for bit 1
- BG_RGB, 24'h000000, colour for bit 0
- BORDER_RGB, 24'h202020, colour for active area outside the image

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- pix_ce  in  1  pixel clock enable; all state advances only when pix_ce=1
- ram_addr  out  32  read address to the frame RAM
- ram_we  out  1  constant 0
- ram_rdata  in  32  RAM read data; only bit 0 is used
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- de  out  1  active-video data enable
- rgb  out  24  {R,G,B}, 8 bits each
- frame_start  out  1  one-tick pulse coincident with the first de of each frame

Behaviour:
- Reset values (async): h=0, v=0, all sub-counters 0, ram_addr=0, hsync=1, vsync=1, de=0, rgb=0, frame_start=0.
- Counters:
  - h wraps 0..799. v increments when h wraps and itself wraps 0..524.
  - Active region is h<640 and v<480.
  - hsync=0 for h in [656,751]; vsync=0 for v in [490,491].
- Image window: h in [X_OFF, X_OFF+IMG_W*SCALE) and v in [Y_OFF, Y_OFF+IMG_H*SCALE).
- Address generation uses no divider:
  - sx counts 0..SCALE-1 across the window; col increments when sx wraps.
  - sy counts per window line; row_base += IMG_W when sy wraps.
  - Outside the window, col resets to 0.
  - At the end of the last window line, row_base resets to 0.
  - ram_addr = row_base + col, registered on the pix_ce tick. Outside the window, ram_addr=0.
- Pipeline: 3 stages, with all outputs lagging the counters by 2 ce ticks.
  - Stage 0: counters.
  - Stage 1: ram_addr register plus delayed window/active/sync flags.
  - Stage 2: rdata[0] is sampled; the RAM has latched the address on the intervening negedge. rgb, de, hsync, vsync and frame_start are registered here.
- Colour mux:
  - not active → 0
  - active, outside window → BORDER_RGB
  - in window → FG_RGB if bit=1, else BG_RGB
- pix_ce=0 holds every register, including outputs.
- rst mid-frame: immediate return to reset values. Scan restarts at h=0, v=0 and the first frame_start follows.
- Widths:
  - h: 10 bits; v: 10 bits.
  - row_base and col: 17 bits, zero-extended to 32.
  - Last address is 57599; no wrap beyond it.

Decomposition:
- Package fb_vga_pkg: timing constants (H/V totals and sync windows), an RGB typedef (packed struct of r, g, b bytes), and the colour constants.
- One sub-module, vga_timing_gen: h/v counters, hsync/vsync/active flags and the frame-start flag.
- The top level holds address generation, pipeline delay and the colour mux.

Test Plan:
- Assert rst, then release with pix_ce=1 → hsync=vsync=1, de=0, rgb=0 after reset. frame_start pulses exactly 2 ticks after counters reach (0,0), and the first de=1 coincides with it.
- Count ticks per line and per frame → 800 per line, 420000 per frame. hsync is low for 96 ticks starting at line tick 658 (656+2). vsync is low for lines 490-491 of the counter.
- Model RAM with bit = addr[0] → ram_addr=0 at (h=80,v=0) and (81,0), =1 at (82,0), =239 at (559,0), =240 at (80,2), =57599 at (559,479).
- Model RAM with bit 1 only at address 0 → rgb=FFFFFF on output pixels (80,0), (81,0), (80,1), (81,1). rgb=000000 at (82,0). rgb=202020 at (0,0) and (639,0). rgb=0 at (700,0).
- Toggle pix_ce 1-0-1 (50% duty) → the output sequence is identical to the pix_ce=1 run, each value held 2 clk. ram_we stays 0 throughout.
- Assert rst at (h=300,v=200) → outputs go to reset values within the same clk without waiting for an edge. After release, the next frame_start arrives after exactly 2 ce ticks.

Source files
------------

// File: rtl/fb_vga_pkg.sv
// Shared timing defaults, pixel colour type and colour constants for the
// 1-bpp framebuffer VGA scanout.
package fb_vga_pkg;

  localparam int H_ACT_DFLT  = 640;
  localparam int H_FP_DFLT   = 16;
  localparam int H_SYNC_DFLT = 96;
  localparam int H_BP_DFLT   = 48;
  localparam int V_ACT_DFLT  = 480;
  localparam int V_FP_DFLT   = 10;
  localparam int V_SYNC_DFLT = 2;
  localparam int V_BP_DFLT   = 33;

  localparam int H_TOTAL_DFLT      = H_ACT_DFLT + H_FP_DFLT + H_SYNC_DFLT + H_BP_DFLT;
  localparam int V_TOTAL_DFLT      = V_ACT_DFLT + V_FP_DFLT + V_SYNC_DFLT + V_BP_DFLT;
  localparam int H_SYNC_START_DFLT = H_ACT_DFLT + H_FP_DFLT;
  localparam int H_SYNC_END_DFLT   = H_SYNC_START_DFLT + H_SYNC_DFLT - 1;
  localparam int V_SYNC_START_DFLT = V_ACT_DFLT + V_FP_DFLT;
  localparam int V_SYNC_END_DFLT   = V_SYNC_START_DFLT + V_SYNC_DFLT - 1;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t FG_RGB_DFLT     = 24'hFFFFFF;
  localparam rgb_t BG_RGB_DFLT     = 24'h000000;
  localparam rgb_t BORDER_RGB_DFLT = 24'h202020;
  localparam rgb_t RGB_OFF         = 24'h000000;

endpackage

// File: rtl/fb_vga_scanout_vga_timing_gen.sv
// Raster counters for VGA timing: h/v position, active-area flag, active-low
// sync flags and a frame-start flag at (0,0). Everything advances on i_ce.
module vga_timing_gen
  import fb_vga_pkg::*;
#(
  parameter int H_ACT  = H_ACT_DFLT,
  parameter int H_FP   = H_FP_DFLT,
  parameter int H_SYNC = H_SYNC_DFLT,
  parameter int H_BP   = H_BP_DFLT,
  parameter int V_ACT  = V_ACT_DFLT,
  parameter int V_FP   = V_FP_DFLT,
  parameter int V_SYNC = V_SYNC_DFLT,
  parameter int V_BP   = V_BP_DFLT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_ce,
  output logic [9:0] o_h,
  output logic [9:0] o_v,
  output logic       o_active,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_frame_start
);

  localparam logic [9:0] H_LAST   = 10'(H_ACT + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_ACT + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_ACT_W  = 10'(H_ACT);
  localparam logic [9:0] V_ACT_W  = 10'(V_ACT);
  localparam logic [9:0] HS_START = 10'(H_ACT + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACT + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_ACT + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACT + V_FP + V_SYNC - 1);

  logic [9:0] r_h;
  logic [9:0] r_v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h <= '0;
      r_v <= '0;
    end else if (i_ce) begin
      if (r_h == H_LAST) begin
        r_h <= '0;
        r_v <= (r_v == V_LAST) ? 10'd0 : r_v + 10'd1;
      end else begin
        r_h <= r_h + 10'd1;
      end
    end
  end

  assign o_h           = r_h;
  assign o_v           = r_v;
  assign o_active      = (r_h < H_ACT_W) && (r_v < V_ACT_W);
  assign o_hsync       = !((r_h >= HS_START) && (r_h <= HS_END));
  assign o_vsync       = !((r_v >= VS_START) && (r_v <= VS_END));
  assign o_frame_start = (r_h == 10'd0) && (r_v == 10'd0);

endmodule

// File: rtl/fb_vga_scanout.sv
// Scans a 1-bpp frame RAM in raster order with integer upscaling and drives
// registered VGA sync/DE/RGB; outputs lag the raster counters by two ce ticks.
module fb_vga_scanout
  import fb_vga_pkg::*;
#(
  parameter int   IMG_W      = 240,
  parameter int   IMG_H      = 240,
  parameter int   SCALE      = 2,
  parameter int   X_OFF      = 80,
  parameter int   Y_OFF      = 0,
  parameter int   H_ACT      = H_ACT_DFLT,
  parameter int   H_FP       = H_FP_DFLT,
  parameter int   H_SYNC     = H_SYNC_DFLT,
  parameter int   H_BP       = H_BP_DFLT,
  parameter int   V_ACT      = V_ACT_DFLT,
  parameter int   V_FP       = V_FP_DFLT,
  parameter int   V_SYNC     = V_SYNC_DFLT,
  parameter int   V_BP       = V_BP_DFLT,
  parameter rgb_t FG_RGB     = FG_RGB_DFLT,
  parameter rgb_t BG_RGB     = BG_RGB_DFLT,
  parameter rgb_t BORDER_RGB = BORDER_RGB_DFLT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_ce,
  output logic [31:0] ram_addr,
  output logic        ram_we,
  input  logic [31:0] ram_rdata,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [23:0] rgb,
  output logic        frame_start
);

  localparam int              SW       = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam logic [SW-1:0]   S_LAST   = SW'(SCALE - 1);
  localparam logic [9:0]      WX0      = 10'(X_OFF);
  localparam logic [9:0]      WY0      = 10'(Y_OFF);
  localparam logic [9:0]      WIN_W    = 10'(IMG_W * SCALE);
  localparam logic [9:0]      WIN_H    = 10'(IMG_H * SCALE);
  localparam logic [9:0]      WX_LAST  = 10'(X_OFF + IMG_W * SCALE - 1);
  localparam logic [9:0]      WY_LAST  = 10'(Y_OFF + IMG_H * SCALE - 1);
  localparam logic [16:0]     ROW_STEP = 17'(IMG_W);

  logic [9:0] w_h;
  logic [9:0] w_v;
  logic       w_active;
  logic       w_hsync;
  logic       w_vsync;
  logic       w_frame_start;
  logic       w_win;
  logic       w_line_end;
  logic       w_last_line;
  rgb_t       w_pix_rgb;
  logic       w_unused_rdata;

  vga_timing_gen #(
    .H_ACT (H_ACT),
    .H_FP  (H_FP),
    .H_SYNC(H_SYNC),
    .H_BP  (H_BP),
    .V_ACT (V_ACT),
    .V_FP  (V_FP),
    .V_SYNC(V_SYNC),
    .V_BP  (V_BP)
  ) u_timing (
    .clk          (clk),
    .rst          (rst),
    .i_ce         (pix_ce),
    .o_h          (w_h),
    .o_v          (w_v),
    .o_active     (w_active),
    .o_hsync      (w_hsync),
    .o_vsync      (w_vsync),
    .o_frame_start(w_frame_start)
  );

  // Unsigned wrap-around makes each window test a single compare.
  assign w_win       = ((w_h - WX0) < WIN_W) && ((w_v - WY0) < WIN_H);
  assign w_line_end  = w_win && (w_h == WX_LAST);
  assign w_last_line = (w_v == WY_LAST);

  // Stage 0 companions: sub-pixel/sub-line counters track the current raster position.
  logic [SW-1:0] r_sx;
  logic [SW-1:0] r_sy;
  logic [16:0]   r_col;
  logic [16:0]   r_row_base;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sx       <= '0;
      r_sy       <= '0;
      r_col      <= '0;
      r_row_base <= '0;
    end else if (pix_ce) begin
      if (w_win) begin
        if (r_sx == S_LAST) begin
          r_sx  <= '0;
          r_col <= r_col + 17'd1;
        end else begin
          r_sx <= r_sx + SW'(1);
        end
      end else begin
        r_sx  <= '0;
        r_col <= '0;
      end
      if (w_line_end) begin
        if (r_sy == S_LAST) begin
          r_sy       <= '0;
          r_row_base <= w_last_line ? 17'd0 : r_row_base + ROW_STEP;
        end else begin
          r_sy <= r_sy + SW'(1);
        end
      end
    end
  end

  logic [16:0] r_addr;
  logic        r_act1;
  logic        r_win1;
  logic        r_hs1;
  logic        r_vs1;
  logic        r_fs1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr <= '0;
      r_act1 <= 1'b0;
      r_win1 <= 1'b0;
      r_hs1  <= 1'b1;
      r_vs1  <= 1'b1;
      r_fs1  <= 1'b0;
    end else if (pix_ce) begin
      r_addr <= w_win ? (r_row_base + r_col) : 17'd0;
      r_act1 <= w_active;
      r_win1 <= w_win;
      r_hs1  <= w_hsync;
      r_vs1  <= w_vsync;
      r_fs1  <= w_frame_start;
    end
  end

  // ram_rdata here reflects r_addr, latched by the RAM on the preceding negedge.
  always_comb begin
    w_pix_rgb = RGB_OFF;
    if (r_act1) begin
      if (!r_win1)          w_pix_rgb = BORDER_RGB;
      else if (ram_rdata[0]) w_pix_rgb = FG_RGB;
      else                  w_pix_rgb = BG_RGB;
    end
  end

  rgb_t r_rgb;
  logic r_de;
  logic r_hsync;
  logic r_vsync;
  logic r_fs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rgb   <= RGB_OFF;
      r_de    <= 1'b0;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
      r_fs    <= 1'b0;
    end else if (pix_ce) begin
      r_rgb   <= w_pix_rgb;
      r_de    <= r_act1;
      r_hsync <= r_hs1;
      r_vsync <= r_vs1;
      r_fs    <= r_fs1;
    end
  end

  assign w_unused_rdata = ^ram_rdata[31:1];

  assign ram_addr    = {15'd0, r_addr};
  assign ram_we      = 1'b0;
  assign rgb         = r_rgb;
  assign de          = r_de;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign frame_start = r_fs;

endmodule

// File: tb/tb_fb_vga_scanout.sv
// Scoreboard bench for fb_vga_scanout: a shortened vertical timing (14 lines)
// keeps whole frames cheap while the horizontal timing stays at 800 ticks.
module tb_fb_vga_scanout;

  localparam int H_TOT = 800;

  typedef enum int {K_ADDR, K_RGB, K_DE, K_HS, K_VS, K_FS} kind_e;
  typedef struct {
    int          tick;
    kind_e       kind;
    logic [31:0] exp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_ce = 1'b1;
  logic [31:0] ram_addr;
  logic        ram_we;
  logic [31:0] ram_rdata = '0;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic [23:0] rgb;
  logic        frame_start;

  logic toggle_mode = 1'b0;
  logic ram_mode    = 1'b0;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_err  = 0;
  int   n_tick = 0;

  fb_vga_scanout #(
    .IMG_H (4),
    .V_ACT (10),
    .V_FP  (1),
    .V_SYNC(2),
    .V_BP  (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_ce     (pix_ce),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_rdata  (ram_rdata),
    .hsync      (hsync),
    .vsync      (vsync),
    .de         (de),
    .rgb        (rgb),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Frame RAM: registered on the falling edge; mode 0 bit=addr[0], mode 1 bit set only at 0.
  initial forever begin
    @(negedge clk);
    ram_rdata = ram_mode ? {31'd0, (ram_addr == 32'd0)} : {31'd0, ram_addr[0]};
  end

  initial forever begin
    @(negedge clk);
    pix_ce = toggle_mode ? ~pix_ce : 1'b1;
  end

  function automatic string kname(input kind_e k);
    case (k)
      K_ADDR:  return "ram_addr";
      K_RGB:   return "rgb";
      K_DE:    return "de";
      K_HS:    return "hsync";
      K_VS:    return "vsync";
      default: return "frame_start";
    endcase
  endfunction

  function automatic logic [31:0] actual(input kind_e k);
    case (k)
      K_ADDR:  return ram_addr;
      K_RGB:   return {8'd0, rgb};
      K_DE:    return {31'd0, de};
      K_HS:    return {31'd0, hsync};
      K_VS:    return {31'd0, vsync};
      default: return {31'd0, frame_start};
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp, input int t);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s tick=%0d got=%h expected=%h", nm, t, act, exp);
    end
  endtask

  task automatic push(input int tick, input kind_e k, input logic [31:0] v);
    exp_t e;
    int   i;
    e.tick = tick;
    e.kind = k;
    e.exp  = v;
    i = 0;
    while (i < sb.size() && sb[i].tick <= tick) i++;
    sb.insert(i, e);
  endtask

  // Address for raster pixel (h,v) shows one tick after it, video outputs two.
  task automatic expect_at(input int h, input int v, input kind_e k, input logic [31:0] val);
    push(v * H_TOT + h + ((k == K_ADDR) ? 1 : 2), k, val);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ram_addr"},    ram_addr,           32'd0, -1);
    check({tag, "_hsync"},       {31'd0, hsync},       32'd1, -1);
    check({tag, "_vsync"},       {31'd0, vsync},       32'd1, -1);
    check({tag, "_de"},          {31'd0, de},          32'd0, -1);
    check({tag, "_rgb"},         {8'd0, rgb},          32'd0, -1);
    check({tag, "_frame_start"}, {31'd0, frame_start}, 32'd0, -1);
  endtask

  task automatic drain(input int max_clk, input string tag);
    int c;
    c = 0;
    while (sb.size() != 0 && c < max_clk) begin
      @(posedge clk);
      c++;
    end
    check({"drain_", tag, "_pending"}, 32'(sb.size()), 32'd0, n_tick);
    sb.delete();
  endtask

  // Monitor: counts ce ticks since reset and checks every expectation due at this tick;
  // ce=0 samples re-check the same tick, so held outputs are verified too.
  initial begin : monitor
    logic ce_s;
    logic rst_s;
    int   i;
    forever begin
      @(posedge clk);
      ce_s  = pix_ce;
      rst_s = rst;
      #1;
      if (rst_s || rst) begin
        n_tick = 0;
      end else begin
        if (ce_s) n_tick++;
        check("ram_we", {31'd0, ram_we}, 32'd0, n_tick);
        while (sb.size() > 0 && sb[0].tick < n_tick) void'(sb.pop_front());
        i = 0;
        while (i < sb.size() && sb[i].tick == n_tick) begin
          check(kname(sb[i].kind), actual(sb[i].kind), sb[i].exp, n_tick);
          i++;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog tick=%0d expected finish", n_tick);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int c;
    repeat (3) @(negedge clk);
    check_reset("por");

    // Continuous ce, RAM bit = addr[0].
    push(1, K_FS, 32'd0);
    expect_at(0, 0, K_FS, 1);      expect_at(1, 0, K_FS, 0);
    expect_at(799, 13, K_FS, 0);   expect_at(0, 14, K_FS, 1);   expect_at(1, 14, K_FS, 0);
    expect_at(80, 0, K_ADDR, 0);   expect_at(81, 0, K_ADDR, 0);  expect_at(82, 0, K_ADDR, 1);
    expect_at(83, 0, K_ADDR, 1);   expect_at(559, 0, K_ADDR, 239); expect_at(560, 0, K_ADDR, 0);
    expect_at(300, 1, K_ADDR, 110); expect_at(80, 2, K_ADDR, 240); expect_at(301, 2, K_ADDR, 350);
    expect_at(81, 3, K_ADDR, 240); expect_at(82, 3, K_ADDR, 241); expect_at(559, 7, K_ADDR, 959);
    expect_at(80, 8, K_ADDR, 0);   expect_at(82, 14, K_ADDR, 1);
    expect_at(0, 0, K_RGB, 32'h202020);   expect_at(79, 0, K_RGB, 32'h202020);
    expect_at(80, 0, K_RGB, 32'h000000);  expect_at(82, 0, K_RGB, 32'hFFFFFF);
    expect_at(84, 0, K_RGB, 32'h000000);  expect_at(559, 0, K_RGB, 32'hFFFFFF);
    expect_at(560, 0, K_RGB, 32'h202020); expect_at(639, 0, K_RGB, 32'h202020);
    expect_at(640, 0, K_RGB, 32'h000000); expect_at(700, 0, K_RGB, 32'h000000);
    expect_at(82, 7, K_RGB, 32'hFFFFFF);  expect_at(80, 8, K_RGB, 32'h202020);
    expect_at(80, 10, K_RGB, 32'h000000);
    expect_at(0, 0, K_DE, 1);   expect_at(639, 0, K_DE, 1); expect_at(640, 0, K_DE, 0);
    expect_at(799, 0, K_DE, 0); expect_at(0, 1, K_DE, 1);   expect_at(639, 9, K_DE, 1);
    expect_at(0, 10, K_DE, 0);  expect_at(0, 13, K_DE, 0);  expect_at(0, 14, K_DE, 1);
    expect_at(655, 0, K_HS, 1); expect_at(656, 0, K_HS, 0); expect_at(751, 0, K_HS, 0);
    expect_at(752, 0, K_HS, 1); expect_at(655, 1, K_HS, 1); expect_at(656, 1, K_HS, 0);
    expect_at(751, 1, K_HS, 0); expect_at(752, 1, K_HS, 1);
    expect_at(799, 10, K_VS, 1); expect_at(0, 11, K_VS, 0);
    expect_at(799, 12, K_VS, 0); expect_at(0, 13, K_VS, 1);
    @(negedge clk);
    rst = 1'b0;
    drain(12000, "cont");

    // ce toggling 1-0-1, RAM bit set only at address 0.
    @(negedge clk);
    rst = 1'b1;
    toggle_mode = 1'b1;
    ram_mode = 1'b1;
    repeat (2) @(negedge clk);
    push(1, K_FS, 32'd0);
    expect_at(0, 0, K_FS, 1);  expect_at(1, 0, K_FS, 0);  expect_at(0, 0, K_DE, 1);
    expect_at(80, 0, K_RGB, 32'hFFFFFF);  expect_at(81, 0, K_RGB, 32'hFFFFFF);
    expect_at(80, 1, K_RGB, 32'hFFFFFF);  expect_at(81, 1, K_RGB, 32'hFFFFFF);
    expect_at(82, 0, K_RGB, 32'h000000);  expect_at(82, 1, K_RGB, 32'h000000);
    expect_at(80, 2, K_RGB, 32'h000000);  expect_at(0, 0, K_RGB, 32'h202020);
    expect_at(639, 0, K_RGB, 32'h202020); expect_at(700, 0, K_RGB, 32'h000000);
    expect_at(82, 0, K_ADDR, 1); expect_at(80, 2, K_ADDR, 240);
    expect_at(655, 0, K_HS, 1);  expect_at(656, 0, K_HS, 0); expect_at(752, 0, K_HS, 1);
    @(negedge clk);
    rst = 1'b0;
    drain(4000, "toggle");

    // Mid-frame reset at (300,5).
    @(negedge clk);
    rst = 1'b1;
    toggle_mode = 1'b0;
    ram_mode = 1'b0;
    expect_at(297, 5, K_ADDR, 588);
    expect_at(296, 5, K_RGB, 32'h000000);
    expect_at(296, 5, K_DE, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    c = 0;
    while (n_tick != 5 * H_TOT + 300 && c < 6000) begin
      @(posedge clk);
      #2;
      c++;
    end
    check("reach_300_5_tick", 32'(n_tick), 32'(5 * H_TOT + 300), n_tick);
    #1;
    rst = 1'b1;
    #1;
    check_reset("mid");
    push(1, K_FS, 32'd0);
    push(1, K_ADDR, 32'd0);
    expect_at(0, 0, K_FS, 1);  expect_at(1, 0, K_FS, 0);
    expect_at(0, 0, K_DE, 1);  expect_at(0, 0, K_HS, 1);
    expect_at(0, 0, K_RGB, 32'h202020);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    drain(100, "rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
